// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S / left-justified codec ADC receiver presenting stereo pairs on valid/ready
module audio_adc_rx #(
  parameter int DATA_WIDTH = 32,
  parameter bit I2S_MODE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic                  adclrck,
  input  logic                  adcdat,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  input  logic                  clear_ovr
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {ALIGN, DELAY, SHIFT, WAIT} state_t;
  state_t state, state_n;
  logic [2:0] bclk_s;
  logic [1:0] lrck_s, dat_s;
  logic lrck_last, chan, left_done, pair_new;
  logic [CW-1:0] bitcnt;
  logic [DATA_WIDTH-1:0] shreg, left_buf, pair_left, pair_right, msb, ins, word;
  logic rise, lr_edge, restart, commit, shift_en, load;
  assign rise = bclk_s[1] & ~bclk_s[2];
  assign lr_edge = rise && (lrck_s[1] != lrck_last);
  assign msb = {dat_s[1], {(DATA_WIDTH-1){1'b0}}};
  assign ins = msb >> bitcnt;
  // a restart commit excludes the current bit, which belongs to the new channel
  assign word = restart ? shreg : (shreg | ins);
  assign load = pair_new && (!out_valid || out_ready);
  always_comb begin
    state_n = state;
    restart = 1'b0;
    commit = 1'b0;
    shift_en = 1'b0;
    if (lr_edge && (state != ALIGN || !lrck_s[1])) begin
      restart = 1'b1;
      commit = state == SHIFT || state == DELAY;
      state_n = I2S_MODE ? DELAY : SHIFT;
    end else if (rise && (state == DELAY || state == SHIFT)) begin
      shift_en = 1'b1;
      commit = bitcnt == CW'(DATA_WIDTH - 1);
      state_n = commit ? WAIT : SHIFT;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) state <= ALIGN;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      bclk_s <= '0;
      lrck_s <= '0;
      dat_s <= '0;
      lrck_last <= 1'b0;
      chan <= 1'b0;
      left_done <= 1'b0;
      pair_new <= 1'b0;
      bitcnt <= '0;
      shreg <= '0;
      left_buf <= '0;
      pair_left <= '0;
      pair_right <= '0;
      out_left <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      bclk_s <= {bclk_s[1:0], bclk};
      lrck_s <= {lrck_s[0], adclrck};
      dat_s <= {dat_s[0], adcdat};
      pair_new <= 1'b0;
      if (rise) lrck_last <= lrck_s[1];
      // left-justified mode takes the MSB on the very rise that reveals the edge
      if (restart) begin
        chan <= lrck_s[1];
        shreg <= I2S_MODE ? '0 : msb;
        bitcnt <= I2S_MODE ? '0 : CW'(1);
      end else if (shift_en) begin
        shreg <= shreg | ins;
        bitcnt <= bitcnt + 1'b1;
      end
      if (commit && !chan) begin
        left_buf <= word;
        left_done <= 1'b1;
      end
      if (commit && chan && left_done) begin
        pair_left <= left_buf;
        pair_right <= word;
        left_done <= 1'b0;
        pair_new <= 1'b1;
      end
      if (load) begin
        out_left <= pair_left;
        out_right <= pair_right;
      end
      out_valid <= load | (out_valid & ~out_ready);
      overrun <= (pair_new & out_valid & ~out_ready) | (overrun & ~clear_ovr);
    end
  end
endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx: scoreboard bench for an I2S instance and a left-justified instance on one bus
module tb_audio_adc_rx;
  logic clk = 0, reset = 0, bclk = 0, adclrck = 0, dat_a = 0, dat_b = 0;
  logic ready_a = 1, clr_a = 0, lat_chk = 0;
  logic [15:0] a_left, a_right, b_left, b_right;
  logic a_valid, b_valid, a_ovr, b_ovr;
  int checks = 0, errors = 0;
  time t_rise_a = 0, t_rise_b = 0;
  logic [31:0] qa[$], qb[$];
  logic pv_a = 0, pr_a = 0;
  logic [31:0] pd_a = 0;
  localparam int SIM_OFS = (20 + 16) * 160 + 80 + 30;

  always #5 clk = ~clk;

  audio_adc_rx #(.DATA_WIDTH(16), .I2S_MODE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bclk(bclk), .adclrck(adclrck), .adcdat(dat_a),
    .out_left(a_left), .out_right(a_right), .out_valid(a_valid), .out_ready(ready_a),
    .overrun(a_ovr), .clear_ovr(clr_a));

  audio_adc_rx #(.DATA_WIDTH(16), .I2S_MODE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bclk(bclk), .adclrck(adclrck), .adcdat(dat_b),
    .out_left(b_left), .out_right(b_right), .out_valid(b_valid), .out_ready(1'b1),
    .overrun(b_ovr), .clear_ovr(1'b0));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // one half-frame; codec changes LRCK/data while bclk is low
  task automatic half(input logic lr, input logic [15:0] w, input int h);
    for (int s = 0; s < h; s++) begin
      bclk = 0;
      adclrck = lr;
      dat_a = (s >= 1 && s <= 16) ? w[16-s] : 1'b0;
      dat_b = (s < 16) ? w[15-s] : 1'b0;
      #80 bclk = 1;
      if (s == 16) t_rise_a = $time;
      if (s == 15) t_rise_b = $time;
      #80;
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int h, input bit pa, input bit pb);
    if (pa) qa.push_back(h >= 17 ? {l, r} : {l & 16'hFFFE, r & 16'hFFFE});
    if (pb) qb.push_back({l, r});
    half(1'b0, l, h);
    half(1'b1, r, h);
  endtask

  task automatic pulse_clr;
    #10 clr_a = 1;
    #10 clr_a = 0;
    #10;
  endtask

  always @(negedge clk) begin
    if (pv_a && !pr_a && a_valid === 1'b1) chk("a_hold", {a_left, a_right}, pd_a);
    if (a_valid === 1'b1 && ready_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got %h expected none", {a_left, a_right});
      end else begin
        chk("a_pair", {a_left, a_right}, qa.pop_front());
        if (lat_chk) chk("a_latency", 32'(($time - t_rise_a) <= 50), 32'd1);
      end
    end
    pv_a = (a_valid === 1'b1);
    pr_a = ready_a;
    pd_a = {a_left, a_right};
  end

  always @(negedge clk) begin
    if (b_valid === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got %h expected none", {b_left, b_right});
      end else begin
        chk("b_pair", {b_left, b_right}, qb.pop_front());
        if (lat_chk) chk("b_latency", 32'(($time - t_rise_b) <= 50), 32'd1);
      end
    end
  end

  initial begin
    half(1'b1, 16'h0000, 4);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_a_left", 32'(a_left), 0);
    chk("rst_a_right", 32'(a_right), 0);
    chk("rst_a_ovr", 32'(a_ovr), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_b_left", 32'(b_left), 0);
    fork
      half(1'b0, 16'hBEEF, 20);
      #800 reset = 1;
    join
    half(1'b1, 16'hCAFE, 20);
    lat_chk = 1;
    frame(16'hA5C3, 16'h1234, 20, 1, 1);
    frame(16'h8001, 16'h7FFE, 20, 1, 1);
    lat_chk = 0;
    frame(16'hFFFF, 16'hFFFF, 16, 1, 1);
    frame(16'h0F0F, 16'hF0F0, 20, 1, 1);
    ready_a = 0;
    frame(16'h1111, 16'h2222, 20, 1, 1);
    frame(16'h3333, 16'h4444, 20, 0, 1);
    frame(16'h5555, 16'h6666, 20, 0, 1);
    chk("bp_valid", 32'(a_valid), 1);
    chk("bp_data", {a_left, a_right}, 32'h11112222);
    chk("bp_ovr", 32'(a_ovr), 1);
    pulse_clr();
    chk("clr_ovr", 32'(a_ovr), 0);
    ready_a = 1;
    #20;
    frame(16'h7777, 16'h8888, 20, 1, 1);
    ready_a = 0;
    frame(16'h9999, 16'hAAAA, 20, 1, 1);
    fork
      frame(16'hBBBB, 16'hCCCC, 20, 1, 1);
      #SIM_OFS ready_a = 1;
    join
    chk("sim_no_ovr", 32'(a_ovr), 0);
    ready_a = 0;
    frame(16'hDDDD, 16'hEEEE, 20, 1, 1);
    chk("pre_coinc_ovr", 32'(a_ovr), 0);
    fork
      frame(16'h1357, 16'h2468, 20, 0, 1);
      begin
        #SIM_OFS clr_a = 1;
        #10 clr_a = 0;
      end
    join
    chk("coinc_ovr", 32'(a_ovr), 1);
    pulse_clr();
    chk("coinc_clr", 32'(a_ovr), 0);
    ready_a = 1;
    #20;
    fork
      half(1'b0, 16'hFACE, 20);
      begin
        #1280 reset = 0;
        #30 reset = 1;
      end
    join
    half(1'b1, 16'hF00D, 20);
    reset = 0;
    fork
      half(1'b1, 16'hABCD, 20);
      #1600 reset = 1;
    join
    frame(16'h1122, 16'h3344, 20, 1, 1);
    frame(16'h5A5A, 16'hA5A5, 20, 1, 1);
    #2000;
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    chk("b_ovr", 32'(b_ovr), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
